// File: rtl/if_fetch.sv
// Instruction fetch front end: issues 8-byte-aligned fetches, buffers returned pairs with their PC for ID.
// Latency: data_ok to inst_valid is 1 cycle (packet FIFO output comes straight from storage flops).
// Backpressure: ID stall holds the head packet; requests need a free FIFO slot per outstanding fetch (credit).
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   br_bus[32:0]           {br_e, br_addr}; br_e redirects fetch to br_addr and flushes buffered packets
//   stall                  ID cannot take the head packet this cycle
//   inst_sram_*            request/response port; responses return in request order
//   pc, inst_valid, inst   head packet toward ID; pc[2]=1 means the lower word is not to be issued
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [32:0] br_bus,
    input  logic        stall,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [63:0] inst_sram_rdata,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic [63:0] inst
);
    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic            br_e;
    logic [31:0]     br_addr;

    logic            started_q, started_d;
    logic            seen_acc_q, seen_acc_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   dis_cnt_q, dis_cnt_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   ipc_head_q, ipc_head_d, ipc_tail_q, ipc_tail_d;
    logic [31:0]     ipc_mem_q [FIFO_DEPTH];
    logic [31:0]     pkt_pc_q  [FIFO_DEPTH];
    logic [63:0]     pkt_dat_q [FIFO_DEPTH];

    logic            accept, resp, drop, push, pop;
    logic [CW:0]     used_slots;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // Every outstanding request owns a packet slot, so a response can always be stored.
    assign used_slots     = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    assign inst_sram_req  = started_q & ~br_e & (used_slots < DEPTH_V);
    assign inst_sram_addr = {fetch_pc_q[31:3], 3'b000};

    assign accept = inst_sram_req & inst_sram_addr_ok;
    // A data_ok with nothing outstanding (stray beat after reset) is ignored.
    assign resp   = inst_sram_data_ok & (out_cnt_q != '0);
    // Wrong-path responses: already marked for discard, or returning in the redirect cycle.
    assign drop   = resp & ((dis_cnt_q != '0) | br_e);
    assign push   = resp & ~drop;

    assign inst_valid = (fifo_cnt_q != '0);
    assign pop        = inst_valid & ~stall & ~br_e;
    assign pc         = pkt_pc_q[head_q];
    assign inst       = pkt_dat_q[head_q];

    always_comb begin
        started_d  = 1'b1;
        seen_acc_d = seen_acc_q | accept;
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q + CW'(accept) - CW'(resp);
        ipc_tail_d = accept ? ipc_tail_q + 1'b1 : ipc_tail_q;
        ipc_head_d = resp   ? ipc_head_q + 1'b1 : ipc_head_q;
        dis_cnt_d  = dis_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (br_e) begin
            // Everything still in flight is wrong-path now, including requests already
            // marked; the response returning this cycle is dropped here directly.
            fetch_pc_d = br_addr;
            dis_cnt_d  = out_cnt_q - CW'(resp);
            fifo_cnt_d = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = {fetch_pc_q[31:3] + 29'd1, 3'b000};
            end
            dis_cnt_d  = dis_cnt_q - CW'(resp & (dis_cnt_q != '0));
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            head_d     = pop  ? head_q + 1'b1 : head_q;
            tail_d     = push ? tail_q + 1'b1 : tail_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started_q  <= 1'b0;
            seen_acc_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            dis_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            ipc_head_q <= '0;
            ipc_tail_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ipc_mem_q[i] <= '0;
                pkt_pc_q[i]  <= '0;
                pkt_dat_q[i] <= '0;
            end
        end else begin
            started_q  <= started_d;
            seen_acc_q <= seen_acc_d;
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            dis_cnt_q  <= dis_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ipc_head_q <= ipc_head_d;
            ipc_tail_q <= ipc_tail_d;
            // Issued PC keeps bit 2 so an unaligned branch target skips the lower word.
            if (accept) begin
                ipc_mem_q[ipc_tail_q] <= fetch_pc_q;
            end
            if (push) begin
                pkt_pc_q[tail_q]  <= ipc_mem_q[ipc_head_q];
                pkt_dat_q[tail_q] <= inst_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (used_slots <= DEPTH_V);
            assert (dis_cnt_q <= out_cnt_q);
            assert (!(inst_sram_data_ok && (out_cnt_q == '0) && seen_acc_q));
        end
    end
endmodule
